// File: rtl/adxl345_pkg.sv
// Shared constants, reset values and FSM state type for the ADXL345 SPI responder.
package adxl345_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE     = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL   = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

  localparam int CMD_RW_BIT            = 7;
  localparam int CMD_MB_BIT            = 6;
  localparam int POWER_CTL_MEASURE_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA
  } resp_state_t;

  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_sync.sv
// 3-stage pin synchronizer for CSN/SCLK/SDI with rise/fall pulses on CSN and SCLK.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_csn,
  input  logic i_sclk,
  input  logic i_sdi,
  output logic o_csn_sync,
  output logic o_sclk_sync,
  output logic o_sdi_sync,
  output logic o_csn_rise,
  output logic o_csn_fall,
  output logic o_sclk_rise,
  output logic o_sclk_fall
);

  // bit 0 = CSN, bit 1 = SCLK, bit 2 = SDI
  localparam logic [2:0] IDLE_LEVEL = 3'b011;

  logic [2:0] w_pin;
  logic [2:0] r_s0, r_s1, r_s2;
  logic [2:0] r_fill;
  logic [1:0] w_rise, w_fall;

  assign w_pin = {i_sdi, i_sclk, i_csn};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0   <= IDLE_LEVEL;
      r_s1   <= IDLE_LEVEL;
      r_s2   <= IDLE_LEVEL;
      r_fill <= '0;
    end else begin
      r_s0   <= w_pin;
      r_s1   <= r_s0;
      r_s2   <= r_s1;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  // Edges are suppressed until the pipeline holds real pin samples, so a pin
  // held low across reset is not mistaken for a fresh edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      assign w_rise[gi] = r_fill[2] &  r_s1[gi] & ~r_s2[gi];
      assign w_fall[gi] = r_fill[2] & ~r_s1[gi] &  r_s2[gi];
    end
  endgenerate

  assign o_csn_sync  = r_s1[0];
  assign o_sclk_sync = r_s1[1];
  assign o_sdi_sync  = r_s1[2];
  assign o_csn_rise  = w_rise[0];
  assign o_csn_fall  = w_fall[0];
  assign o_sclk_rise = w_rise[1];
  assign o_sclk_fall = w_fall[1];

endmodule

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 target emulating a reduced ADXL345 register map, oversampled in clk.
// Optional ADXL_RESP_SHADOW_EN: snapshot data bytes at CS fall for atomic burst reads.
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter int         CLK_RATIO_MIN = 8,
  parameter logic [7:0] DEVID_VALUE   = 8'hE5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  reg_bw_rate,
  output logic [7:0]  reg_power_ctl,
  output logic [7:0]  reg_data_format,
  output logic        data_ready,
  output logic        busy
);

  localparam logic [3:0] SCLK_LOW_MIN = 4'(CLK_RATIO_MIN / 2 - 1);

  logic w_csn_sync, w_sclk_sync, w_sdi_sync;
  logic w_csn_rise, w_csn_fall, w_sclk_rise, w_sclk_fall;

  resp_state_t r_state, w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_tx;
  logic [5:0]  r_addr;
  logic        r_mb, r_sdo, r_rd_data_seen, r_data_ready, r_busy;
  logic [7:0]  r_bw_rate, r_power_ctl, r_data_format;
  logic [7:0]  r_data [6];
  logic [7:0]  w_rd_src [6];
  logic [7:0]  w_byte, w_rd_byte;
  logic [5:0]  w_next_addr, w_load_addr;
  logic [2:0]  w_data_idx;
  logic        w_byte_done, w_capture;
  logic [3:0]  r_sclk_low_cnt;

  spi_pin_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_csn      (spi_csn),
    .i_sclk     (spi_sclk),
    .i_sdi      (spi_sdi),
    .o_csn_sync (w_csn_sync),
    .o_sclk_sync(w_sclk_sync),
    .o_sdi_sync (w_sdi_sync),
    .o_csn_rise (w_csn_rise),
    .o_csn_fall (w_csn_fall),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall)
  );

  assign w_byte      = {r_shift[6:0], w_sdi_sync};
  assign w_byte_done = w_sclk_rise && !w_csn_rise && !w_csn_fall &&
                       (r_bit_cnt == 3'd7) && (r_state != ST_IDLE);
  assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;
  // The byte to load is either the one the command just addressed or the next in the burst.
  assign w_load_addr = (r_state == ST_CMD) ? w_byte[5:0] : w_next_addr;
  assign w_data_idx  = 3'(w_load_addr - ADDR_DATAX0);
  assign w_capture   = sample_valid && r_power_ctl[POWER_CTL_MEASURE_BIT];

`ifdef ADXL_RESP_SHADOW_EN
  logic [7:0] r_shadow [6];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
    end else if (w_csn_fall) begin
      for (int i = 0; i < 6; i++) r_shadow[i] <= r_data[i];
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_src
      assign w_rd_src[gi] = r_shadow[gi];
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_src
      assign w_rd_src[gi] = r_data[gi];
    end
  endgenerate
`endif

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_load_addr)
      ADDR_DEVID:       w_rd_byte = DEVID_VALUE;
      ADDR_BW_RATE:     w_rd_byte = r_bw_rate;
      ADDR_POWER_CTL:   w_rd_byte = r_power_ctl;
      ADDR_INT_SOURCE:  w_rd_byte = {r_data_ready, 7'b0};
      ADDR_DATA_FORMAT: w_rd_byte = r_data_format;
      default:          if (is_data_addr(w_load_addr)) w_rd_byte = w_rd_src[w_data_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_csn_rise)
      w_state_next = ST_IDLE;
    else if (w_csn_fall)
      w_state_next = ST_CMD;
    else if (r_state == ST_CMD && w_byte_done)
      w_state_next = w_byte[CMD_RW_BIT] ? ST_RD_DATA : ST_WR_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_tx           <= '0;
      r_addr         <= '0;
      r_mb           <= 1'b0;
      r_sdo          <= 1'b0;
      r_rd_data_seen <= 1'b0;
      r_data_ready   <= 1'b0;
      r_busy         <= 1'b0;
      r_bw_rate      <= RST_BW_RATE;
      r_power_ctl    <= RST_POWER_CTL;
      r_data_format  <= RST_DATA_FORMAT;
      for (int i = 0; i < 6; i++) r_data[i] <= '0;
    end else begin
      if (w_csn_fall) begin
        r_bit_cnt      <= '0;
        r_sdo          <= 1'b0;
        r_rd_data_seen <= 1'b0;
      end else if (w_sclk_rise && r_state != ST_IDLE) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_byte_done) begin
        case (r_state)
          ST_CMD: begin
            r_addr <= w_byte[5:0];
            r_mb   <= w_byte[CMD_MB_BIT];
            r_tx   <= w_rd_byte;
          end
          ST_WR_DATA: begin
            r_addr <= w_next_addr;
            case (r_addr)
              ADDR_BW_RATE:     r_bw_rate     <= w_byte;
              ADDR_POWER_CTL:   r_power_ctl   <= w_byte;
              ADDR_DATA_FORMAT: r_data_format <= w_byte;
              default: ;
            endcase
          end
          ST_RD_DATA: begin
            r_addr <= w_next_addr;
            r_tx   <= w_rd_byte;
            if (is_data_addr(r_addr)) r_rd_data_seen <= 1'b1;
          end
          default: ;
        endcase
      end

      if (w_sclk_fall && r_state == ST_RD_DATA) begin
        r_sdo <= r_tx[7];
        r_tx  <= {r_tx[6:0], 1'b0};
      end

      if (w_capture) begin
        r_data[0] <= sample_x[7:0];
        r_data[1] <= sample_x[15:8];
        r_data[2] <= sample_y[7:0];
        r_data[3] <= sample_y[15:8];
        r_data[4] <= sample_z[7:0];
        r_data[5] <= sample_z[15:8];
      end

      // A capture on the same cycle as the clearing CS rise keeps data_ready set.
      if (w_capture)
        r_data_ready <= 1'b1;
      else if (w_csn_rise && r_rd_data_seen)
        r_data_ready <= 1'b0;

      if (w_csn_fall)      r_busy <= 1'b1;
      else if (w_csn_rise) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_sclk_sync)       r_sclk_low_cnt <= '0;
    else if (r_sclk_low_cnt != 4'hF) r_sclk_low_cnt <= r_sclk_low_cnt + 4'd1;
  end

  a_sclk_ratio: assert property (@(posedge clk) disable iff (reset)
    w_sclk_rise |-> (r_sclk_low_cnt >= SCLK_LOW_MIN));

  assign sdo_oe          = (r_state == ST_RD_DATA) && !w_csn_sync;
  assign spi_sdo         = sdo_oe & r_sdo;
  assign reg_bw_rate     = r_bw_rate;
  assign reg_power_ctl   = r_power_ctl;
  assign reg_data_format = r_data_format;
  assign data_ready      = r_data_ready;
  assign busy            = r_busy;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Self-checking bench: SPI mode-3 initiator model plus register-map reference model.
module tb_adxl345_spi_responder;

  localparam int SCLK_HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_csn, spi_sclk, spi_sdi, spi_sdo, sdo_oe;
  logic [15:0] sx, sy, sz;
  logic        sample_valid;
  logic [7:0]  reg_bw_rate, reg_power_ctl, reg_data_format;
  logic        data_ready, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_buf  [8];
  logic [7:0] rx_buf  [8];
  logic [7:0] exp_buf [8];

  // reference model state
  logic [7:0] m_bw, m_pwr, m_fmt;
  logic       m_dr;
  logic [7:0] m_live [6];

  always #20 clk = ~clk;

  adxl345_spi_responder dut (
    .clk            (clk),
    .reset          (reset),
    .spi_csn        (spi_csn),
    .spi_sclk       (spi_sclk),
    .spi_sdi        (spi_sdi),
    .spi_sdo        (spi_sdo),
    .sdo_oe         (sdo_oe),
    .sample_x       (sx),
    .sample_y       (sy),
    .sample_z       (sz),
    .sample_valid   (sample_valid),
    .reg_bw_rate    (reg_bw_rate),
    .reg_power_ctl  (reg_power_ctl),
    .reg_data_format(reg_data_format),
    .data_ready     (data_ready),
    .busy           (busy)
  );

  function automatic logic [7:0] m_read(input logic [5:0] a);
    if (a == 6'h00) return 8'hE5;
    if (a == 6'h2C) return m_bw;
    if (a == 6'h2D) return m_pwr;
    if (a == 6'h30) return {m_dr, 7'b0};
    if (a == 6'h31) return m_fmt;
    if (a >= 6'h32 && a <= 6'h37) return m_live[int'(a) - 32'h32];
    return 8'h00;
  endfunction

  function automatic logic [7:0] byte_of(input logic [15:0] x, y, z, input int k);
    logic [15:0] w;
    w = (k < 2) ? x : (k < 4) ? y : z;
    return (k % 2 == 0) ? w[7:0] : w[15:8];
  endfunction

  // Applies one complete transaction (command in tx_buf[0]) to the model.
  task automatic model_txn(input int ndata);
    logic [5:0] a, ak;
    logic       any_data;
    a = tx_buf[0][5:0];
    any_data = 1'b0;
    for (int k = 0; k < ndata; k++) begin
      ak = tx_buf[0][6] ? 6'(int'(a) + k) : a;
      if (tx_buf[0][7]) begin
        exp_buf[k+1] = m_read(ak);
        if (ak >= 6'h32 && ak <= 6'h37) any_data = 1'b1;
      end else begin
        if (ak == 6'h2C) m_bw  = tx_buf[k+1];
        if (ak == 6'h2D) m_pwr = tx_buf[k+1];
        if (ak == 6'h31) m_fmt = tx_buf[k+1];
      end
    end
    if (any_data) m_dr = 1'b0;
  endtask

  task automatic pulse_sample(input logic [15:0] x, y, z);
    @(negedge clk);
    sx = x; sy = y; sz = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    if (m_pwr[3]) begin
      for (int k = 0; k < 6; k++) m_live[k] = byte_of(x, y, z, k);
      m_dr = 1'b1;
    end
  endtask

  // Mode-3 initiator: nbytes bytes from tx_buf, last one truncated to last_bits.
  // Optional sample strobe after byte pulse_after, and one timed on the detected CS rise.
  task automatic spi_xfer(input int nbytes, input int last_bits, input int pulse_after,
                          input logic [15:0] px, py, pz, input bit end_pulse,
                          input logic [15:0] ex, ey, ez);
    logic is_read, exp_oe, oe_bad;
    int   nb;
    is_read = tx_buf[0][7];
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      nb     = (b == nbytes - 1) ? last_bits : 8;
      exp_oe = is_read && (b > 0);
      oe_bad = 1'b0;
      for (int i = 0; i < nb; i++) begin
        spi_sclk = 1'b0;
        spi_sdi  = tx_buf[b][7-i];
        repeat (SCLK_HALF) @(negedge clk);
        if (sdo_oe !== exp_oe) oe_bad = 1'b1;
        rx_buf[b][7-i] = spi_sdo;
        spi_sclk = 1'b1;
        repeat (SCLK_HALF) @(negedge clk);
      end
      if (nb == 8) begin
        checks++;
        if (oe_bad) begin
          errors++;
          $display("FAIL sdo_oe byte %0d cmd %02h: level wrong, expected %0b", b, tx_buf[0], exp_oe);
        end
      end
      if (b == pulse_after) begin
        sx = px; sy = py; sz = pz; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_active: got %b expected 1", busy);
    end
    repeat (2) @(negedge clk);
    spi_csn = 1'b1;
    if (end_pulse) begin
      // CS rise is acted on at the third clk edge after the pin change.
      @(negedge clk);
      @(negedge clk);
      sx = ex; sy = ey; sz = ez; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sdo_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_cs: busy %b sdo_oe %b expected 0 0", busy, sdo_oe);
    end
  endtask

  task automatic test_reset;
    spi_csn = 1'b1; spi_sclk = 1'b1; spi_sdi = 1'b0;
    sample_valid = 1'b0; sx = '0; sy = '0; sz = '0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    m_bw = 8'h0A; m_pwr = 8'h00; m_fmt = 8'h00; m_dr = 1'b0;
    for (int k = 0; k < 6; k++) m_live[k] = 8'h00;
    checks++;
    if (reg_bw_rate !== 8'h0A) begin errors++; $display("FAIL reset_bw_rate: got %02h expected 0a", reg_bw_rate); end
    checks++;
    if (reg_power_ctl !== 8'h00 || reg_data_format !== 8'h00) begin
      errors++; $display("FAIL reset_ctl_fmt: got %02h %02h expected 00 00", reg_power_ctl, reg_data_format);
    end
    checks++;
    if (data_ready !== 1'b0 || busy !== 1'b0 || sdo_oe !== 1'b0 || spi_sdo !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: dr %b busy %b oe %b sdo %b expected all 0", data_ready, busy, sdo_oe, spi_sdo);
    end
    $display("reset done");
  endtask

  task automatic test_devid;
    tx_buf[0] = 8'h80;
    spi_xfer(2, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    checks++;
    if (rx_buf[1] !== 8'hE5) begin errors++; $display("FAIL devid: got %02h expected e5", rx_buf[1]); end
    $display("read devid -> %02h", rx_buf[1]);
  endtask

  task automatic test_measure_capture;
    logic [15:0] y, z;
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08;
    model_txn(1);
    spi_xfer(2, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    checks++;
    if (reg_power_ctl !== 8'h08) begin errors++; $display("FAIL power_ctl_write: got %02h expected 08", reg_power_ctl); end
    y = 16'($urandom); z = 16'($urandom);
    pulse_sample(16'hFF38, y, z);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL data_ready_set: got %b expected 1", data_ready); end
    tx_buf[0] = 8'hF2;
    model_txn(2);
    spi_xfer(3, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    checks++;
    if (rx_buf[1] !== 8'h38 || rx_buf[2] !== 8'hFF) begin
      errors++; $display("FAIL datax_read: got %02h %02h expected 38 ff", rx_buf[1], rx_buf[2]);
    end
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL data_ready_clear: got %b expected 0", data_ready); end
    $display("measure capture: datax %02h%02h", rx_buf[2], rx_buf[1]);
  endtask

  task automatic test_no_measure;
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h00;
    model_txn(1);
    spi_xfer(2, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    pulse_sample(16'h1234, 16'h5678, 16'h9ABC);
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL standby_data_ready: got %b expected 0", data_ready); end
    tx_buf[0] = 8'hF2;
    model_txn(6);
    spi_xfer(7, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (rx_buf[k] !== exp_buf[k]) begin
        errors++; $display("FAIL standby_data byte %0d: got %02h expected %02h", k, rx_buf[k], exp_buf[k]);
      end
    end
    $display("standby sample ignored, datax %02h%02h", rx_buf[2], rx_buf[1]);
  endtask

  task automatic test_wrap;
    tx_buf[0] = 8'hFE;
    model_txn(6);
    spi_xfer(7, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (rx_buf[k] !== exp_buf[k]) begin
        errors++; $display("FAIL wrap byte %0d: got %02h expected %02h", k, rx_buf[k], exp_buf[k]);
      end
    end
    $display("wrap read 3e..03: %02h %02h %02h %02h %02h %02h",
             rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4], rx_buf[5], rx_buf[6]);
  endtask

  task automatic test_abort;
    tx_buf[0] = 8'h31; tx_buf[1] = 8'hFF;
    spi_xfer(2, 4, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    checks++;
    if (reg_data_format !== 8'h00) begin errors++; $display("FAIL abort_format: got %02h expected 00", reg_data_format); end
    tx_buf[0] = 8'h31; tx_buf[1] = 8'h0B;
    model_txn(1);
    spi_xfer(2, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    checks++;
    if (reg_data_format !== m_fmt) begin
      errors++; $display("FAIL post_abort_write: got %02h expected %02h", reg_data_format, m_fmt);
    end
    $display("abort then write data_format -> %02h", reg_data_format);
  endtask

  task automatic test_random;
    logic [5:0] addr_tab [9];
    logic [5:0] a;
    int         nd;
    addr_tab = '{6'h00, 6'h2C, 6'h2D, 6'h30, 6'h31, 6'h32, 6'h34, 6'h36, 6'h3F};
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0)
        pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      a = ($urandom_range(0, 9) == 9) ? 6'($urandom) : addr_tab[$urandom_range(0, 8)];
      tx_buf[0] = {1'($urandom), 1'($urandom), a};
      nd = $urandom_range(1, 4);
      for (int k = 1; k <= nd; k++) tx_buf[k] = 8'($urandom);
      model_txn(nd);
      spi_xfer(nd + 1, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
      if (tx_buf[0][7]) begin
        for (int k = 1; k <= nd; k++) begin
          checks++;
          if (rx_buf[k] !== exp_buf[k]) begin
            errors++;
            $display("FAIL rand_read it %0d cmd %02h byte %0d: got %02h expected %02h",
                     it, tx_buf[0], k, rx_buf[k], exp_buf[k]);
          end
        end
      end
      checks++;
      if (reg_bw_rate !== m_bw || reg_power_ctl !== m_pwr || reg_data_format !== m_fmt || data_ready !== m_dr) begin
        errors++;
        $display("FAIL rand_regs it %0d: got %02h %02h %02h %b expected %02h %02h %02h %b", it,
                 reg_bw_rate, reg_power_ctl, reg_data_format, data_ready, m_bw, m_pwr, m_fmt, m_dr);
      end
      $display("txn %0d cmd %02h len %0d first %02h", it, tx_buf[0], nd, rx_buf[1]);
    end
  endtask

  task automatic test_mid_burst;
    logic [15:0] ax, ay, az, bx, by, bz, cx, cy, cz;
    logic [7:0]  expd;
    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08;
    model_txn(1);
    spi_xfer(2, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
    bx = ~ax; by = ~ay; bz = ~az;
    cx = 16'($urandom); cy = 16'($urandom); cz = 16'($urandom);
    pulse_sample(ax, ay, az);
    tx_buf[0] = 8'hF2;
    spi_xfer(7, 8, 2, bx, by, bz, 1'b1, cx, cy, cz);
    for (int k = 0; k < 6; k++) begin
`ifdef ADXL_RESP_SHADOW_EN
      expd = byte_of(ax, ay, az, k);
`else
      expd = (k <= 2) ? byte_of(ax, ay, az, k) : byte_of(bx, by, bz, k);
`endif
      checks++;
      if (rx_buf[k+1] !== expd) begin
        errors++; $display("FAIL mid_burst byte %0d: got %02h expected %02h", k, rx_buf[k+1], expd);
      end
    end
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", data_ready); end
    for (int k = 0; k < 6; k++) m_live[k] = byte_of(cx, cy, cz, k);
    m_dr = 1'b1;
    tx_buf[0] = 8'hF2;
    model_txn(6);
    spi_xfer(7, 8, -1, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (rx_buf[k] !== exp_buf[k]) begin
        errors++; $display("FAIL final_sample byte %0d: got %02h expected %02h", k, rx_buf[k], exp_buf[k]);
      end
    end
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL final_clear: got %b expected 0", data_ready); end
    $display("mid-burst sample: x read %02h%02h", rx_buf[2], rx_buf[1]);
  endtask

  initial begin
    test_reset();
    test_devid();
    test_measure_capture();
    test_no_measure();
    test_wrap();
    test_abort();
    test_random();
    test_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
